// File: rtl/reqbus_wb_bridge_pkg.sv
// Shared types and constants for the request-bus to Wishbone bridge.
package reqbus_wb_bridge_pkg;

    localparam logic [2:0] LEN_SINGLE = 3'd1;
    localparam logic [2:0] LEN_LINE   = 3'd4;

    localparam int unsigned FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWrWait,
        StWrCyc,
        StRdCyc
    } state_e;

    // Word address of a beat; line bursts wrap inside the 16-byte line.
    function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [1:0] beat);
        logic [1:0] word;
        word = base[3:2] + beat;
        return {base[31:4], word, 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo4.sv
// 32-bit synchronous FIFO with combinational head and synchronous flush.
module sync_fifo4
    import reqbus_wb_bridge_pkg::*;
(
    input  logic        clk_i,
    input  logic        flush_i,
    input  logic        push_i,
    input  logic [31:0] wdata_i,
    input  logic        pop_i,
    output logic [31:0] rdata_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    logic [31:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == (PtrW + 1)'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{PtrW{1'b0}}, do_push} - {{PtrW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/reqbus_wb_bridge.sv
// Responder for CPU request/write/read streams; issues one Wishbone classic cycle per beat,
// buffering write and read data in small FIFOs, with a bus-error and timeout path.
module reqbus_wb_bridge
    import reqbus_wb_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_len,
    input  logic [3:0]  req_mask,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic        write_valid,
    input  logic [31:0] write_data,
    output logic        read_valid,
    output logic [31:0] read_data,
    input  logic        read_ack,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        bus_err,
    output logic        req_overrun
);

    localparam int unsigned     TmoW    = $clog2(TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [31:0]     base_q, base_d;
    logic [2:0]      len_q, len_d;
    logic [2:0]      beat_q, beat_d;
    logic [3:0]      sel_q, sel_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [31:0]     adr_q, adr_d;
    logic [3:0]      wsel_q, wsel_d;
    logic [31:0]     dat_q, dat_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            bus_err_q, bus_err_d;
    logic            overrun_q, overrun_d;

    logic        wr_push, wr_pop, wr_full, wr_empty;
    logic [31:0] wr_head;
    logic        rd_push, rd_full, rd_empty;
    logic [31:0] rd_wdata;

    logic       req_line;
    logic [3:0] req_sel;
    logic       tmo_hit;
    logic       term;
    logic       err_beat;
    logic       last_beat;

    assign req_line  = (req_len == LEN_LINE);
    assign req_sel   = req_line ? 4'hF : req_mask;
    assign tmo_hit   = (tmo_q == TmoLast);
    assign term      = cyc_q & (wb_ack_i | wb_err_i | tmo_hit);
    // Error wins over ack; a timeout only counts if the slave stayed silent.
    assign err_beat  = wb_err_i | (tmo_hit & ~wb_ack_i);
    assign last_beat = ((beat_q + 3'd1) == len_q);
    assign wr_push   = write_valid & ~wr_full;

    sync_fifo4 u_wr_fifo (
        .clk_i   (clk_i),
        .flush_i (rst_i),
        .push_i  (wr_push),
        .wdata_i (write_data),
        .pop_i   (wr_pop),
        .rdata_o (wr_head),
        .full_o  (wr_full),
        .empty_o (wr_empty)
    );

    sync_fifo4 u_rd_fifo (
        .clk_i   (clk_i),
        .flush_i (rst_i),
        .push_i  (rd_push),
        .wdata_i (rd_wdata),
        .pop_i   (read_ack),
        .rdata_o (read_data),
        .full_o  (rd_full),
        .empty_o (rd_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (req_valid) state_d = req_we ? StWrWait : StRdCyc;
            StWrWait: if (!wr_empty) state_d = StWrCyc;
            StWrCyc:  if (term) state_d = last_beat ? StIdle : StWrWait;
            StRdCyc:  if (term && last_beat) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        base_d    = base_q;
        len_d     = len_q;
        sel_d     = sel_q;
        beat_d    = beat_q;
        cyc_d     = term ? 1'b0 : cyc_q;
        we_d      = we_q;
        adr_d     = adr_q;
        wsel_d    = wsel_q;
        dat_d     = dat_q;
        tmo_d     = cyc_q ? tmo_q + 1'b1 : tmo_q;
        wr_pop    = 1'b0;
        rd_push   = 1'b0;
        rd_wdata  = err_beat ? ERR_DATA : wb_dat_i;
        bus_err_d = term & err_beat;
        overrun_d = req_valid & (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    base_d = req_addr;
                    len_d  = req_line ? LEN_LINE : LEN_SINGLE;
                    sel_d  = req_sel;
                    beat_d = '0;
                    // Reads start straight from idle to meet the one-cycle request latency.
                    if (!req_we && !rd_full) begin
                        cyc_d  = 1'b1;
                        we_d   = 1'b0;
                        adr_d  = beat_addr(req_addr, 2'd0);
                        wsel_d = req_sel;
                        tmo_d  = '0;
                    end
                end
            end
            StWrWait: begin
                if (!wr_empty) begin
                    cyc_d  = 1'b1;
                    we_d   = 1'b1;
                    adr_d  = beat_addr(base_q, beat_q[1:0]);
                    wsel_d = sel_q;
                    dat_d  = wr_head;
                    tmo_d  = '0;
                end
            end
            StWrCyc: begin
                if (term) begin
                    wr_pop = 1'b1;
                    beat_d = beat_q + 3'd1;
                end
            end
            StRdCyc: begin
                if (term) begin
                    rd_push = 1'b1;
                    beat_d  = beat_q + 3'd1;
                end else if (!cyc_q && !rd_full) begin
                    cyc_d  = 1'b1;
                    we_d   = 1'b0;
                    adr_d  = beat_addr(base_q, beat_q[1:0]);
                    wsel_d = sel_q;
                    tmo_d  = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_q    <= '0;
            len_q     <= LEN_SINGLE;
            sel_q     <= '0;
            beat_q    <= '0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            wsel_q    <= '0;
            dat_q     <= '0;
            tmo_q     <= '0;
            bus_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            base_q    <= base_d;
            len_q     <= len_d;
            sel_q     <= sel_d;
            beat_q    <= beat_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            wsel_q    <= wsel_d;
            dat_q     <= dat_d;
            tmo_q     <= tmo_d;
            bus_err_q <= bus_err_d;
            overrun_q <= overrun_d;
        end
    end

    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_sel_o    = wsel_q;
    assign wb_dat_o    = dat_q;
    assign read_valid  = ~rd_empty;
    assign req_ready   = wr_empty & (state_q != StWrCyc);
    assign bus_err     = bus_err_q;
    assign req_overrun = overrun_q;

endmodule

// File: tb/tb_reqbus_wb_bridge.sv
// Scoreboard bench for reqbus_wb_bridge: stimulus queues expected Wishbone beats and read
// data; a monitor compares them as the bridge presents cycles and read-FIFO pops.
module tb_reqbus_wb_bridge;

    localparam int unsigned Timeout = 255;
    localparam logic [31:0] ErrData = 32'hFFFF_FFFF;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_len;
    logic [3:0]  req_mask;
    logic [31:0] req_addr;
    logic        req_we;
    logic        write_valid;
    logic [31:0] write_data;
    logic        read_valid;
    logic [31:0] read_data;
    logic        read_ack;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        bus_err;
    logic        req_overrun;

    always #5 clk_i = ~clk_i;

    reqbus_wb_bridge #(
        .TIMEOUT  (Timeout),
        .ERR_DATA (ErrData)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_len     (req_len),
        .req_mask    (req_mask),
        .req_addr    (req_addr),
        .req_we      (req_we),
        .write_valid (write_valid),
        .write_data  (write_data),
        .read_valid  (read_valid),
        .read_data   (read_data),
        .read_ack    (read_ack),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_adr_o    (wb_adr_o),
        .wb_sel_o    (wb_sel_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .wb_err_i    (wb_err_i),
        .bus_err     (bus_err),
        .req_overrun (req_overrun)
    );

    typedef struct packed {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
    } wb_exp_t;

    wb_exp_t     exp_wb[$];
    logic [31:0] exp_rd[$];
    logic [31:0] slv_q[$];

    int slv_mode  = 0;  // 0 ack, 1 err, 2 silent
    int slv_delay = 2;
    int errors    = 0;
    int checks    = 0;
    int wb_starts = 0;
    int cyc_len   = 0;
    int last_cyc_len = 0;
    int bus_err_cnt  = 0;
    int overrun_cnt  = 0;
    logic prev_cyc = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin : monitor
        wb_exp_t e;
        logic [31:0] r;
        forever begin
            @(negedge clk_i);
            if (wb_cyc_o && !prev_cyc) begin
                wb_starts++;
                if (exp_wb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: cycle at adr %h, none expected", wb_adr_o);
                end else begin
                    e = exp_wb.pop_front();
                    check("wb_adr", wb_adr_o, e.adr);
                    check("wb_sel", {28'd0, wb_sel_o}, {28'd0, e.sel});
                    check("wb_we", {31'd0, wb_we_o}, {31'd0, e.we});
                    check("wb_stb", {31'd0, wb_stb_o}, 32'd1);
                    if (e.we) check("wb_dat", wb_dat_o, e.dat);
                end
            end
            if (wb_cyc_o) begin
                cyc_len++;
            end else if (prev_cyc) begin
                last_cyc_len = cyc_len;
                cyc_len = 0;
            end
            prev_cyc = wb_cyc_o;
            if (read_valid && read_ack) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: popped %h, none expected", read_data);
                end else begin
                    r = exp_rd.pop_front();
                    check("rd_data", read_data, r);
                end
            end
            if (bus_err) bus_err_cnt++;
            if (req_overrun) overrun_cnt++;
        end
    end

    // Wishbone slave: responds slv_delay cycles into each cycle, data from slv_q.
    initial begin : slave
        int scnt = 0;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            if (wb_cyc_o) begin
                scnt++;
                if (slv_mode != 2 && scnt == slv_delay) begin
                    if (slv_mode == 1) begin
                        wb_err_i = 1'b1;
                    end else begin
                        wb_ack_i = 1'b1;
                        if (!wb_we_o) wb_dat_i = (slv_q.size() != 0) ? slv_q.pop_front()
                                                                      : 32'hBAD0_0000;
                    end
                end
            end else begin
                scnt = 0;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [2:0] l, input logic [3:0] m,
                         input logic w);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        req_mask  = m;
        req_we    = w;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic exp_beat(input logic [31:0] a, input logic [3:0] s, input logic w,
                            input logic [31:0] d);
        wb_exp_t e;
        e.adr = a;
        e.sel = s;
        e.we  = w;
        e.dat = d;
        exp_wb.push_back(e);
    endtask

    task automatic wr_beat(input logic [31:0] d);
        write_valid = 1'b1;
        write_data  = d;
        tick();
        write_valid = 1'b0;
    endtask

    task automatic wait_wb(input string name, input int budget);
        int n = 0;
        while ((exp_wb.size() != 0 || wb_cyc_o) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_wb_done"}, exp_wb.size() + {31'd0, wb_cyc_o}, 32'd0);
        exp_wb.delete();
        repeat (2) tick();
    endtask

    task automatic drain_rd(input string name, input int budget);
        int n = 0;
        while (exp_rd.size() != 0 && n < budget) begin
            read_ack = read_valid;
            tick();
            n++;
        end
        read_ack = 1'b0;
        check({name, "_rd_drained"}, exp_rd.size(), 32'd0);
        exp_rd.delete();
    endtask

    initial begin : stimulus
        int lat;
        int starts0;
        int n;
        logic [31:0] d;

        rst_i       = 1'b1;
        req_valid   = 1'b0;
        req_len     = 3'd1;
        req_mask    = 4'h0;
        req_addr    = '0;
        req_we      = 1'b0;
        write_valid = 1'b0;
        write_data  = '0;
        read_ack    = 1'b0;
        repeat (3) tick();

        check("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        check("rst_we", {31'd0, wb_we_o}, 32'd0);
        check("rst_adr", wb_adr_o, 32'd0);
        check("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_read_valid", {31'd0, read_valid}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        check("rst_overrun", {31'd0, req_overrun}, 32'd0);
        rst_i = 1'b0;
        tick();

        // Single read: cyc in cycle 1, ack in cycle 2, read_valid in cycle 3.
        slv_q.push_back(32'hDEAD_BEEF);
        exp_beat(32'h0000_1008, 4'hF, 1'b0, 32'd0);
        exp_rd.push_back(32'hDEAD_BEEF);
        req_valid = 1'b1;
        req_addr  = 32'h0000_1008;
        req_len   = 3'd1;
        req_mask  = 4'hF;
        req_we    = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            tick();
            if (c == 1) begin
                req_valid = 1'b0;
                check("t1_cyc_cycle1", {31'd0, wb_cyc_o}, 32'd1);
            end
            if (read_valid) lat = c;
        end
        check("t1_read_latency", lat, 32'd3);
        drain_rd("t1", 10);
        read_ack = 1'b1;
        tick();
        read_ack = 1'b0;
        tick();
        check("t1_ack_on_empty", {31'd0, read_valid}, 32'd0);

        // Byte write: address aligned down, mask passed through.
        exp_beat(32'h0000_2000, 4'b0001, 1'b1, 32'h0000_00AA);
        issue(32'h0000_2003, 3'd1, 4'b0001, 1'b1);
        repeat (2) begin
            check("t2_req_ready_wait", {31'd0, req_ready}, 32'd1);
            tick();
        end
        wr_beat(32'h0000_00AA);
        wait_wb("t2", 50);

        // Line read, read_ack withheld: all four beats land in the read FIFO.
        slv_q.push_back(32'h1111_1111);
        slv_q.push_back(32'h2222_2222);
        slv_q.push_back(32'h3333_3333);
        slv_q.push_back(32'h4444_4444);
        exp_beat(32'h0000_3008, 4'hF, 1'b0, 32'd0);
        exp_beat(32'h0000_300C, 4'hF, 1'b0, 32'd0);
        exp_beat(32'h0000_3000, 4'hF, 1'b0, 32'd0);
        exp_beat(32'h0000_3004, 4'hF, 1'b0, 32'd0);
        exp_rd.push_back(32'h1111_1111);
        exp_rd.push_back(32'h2222_2222);
        exp_rd.push_back(32'h3333_3333);
        exp_rd.push_back(32'h4444_4444);
        issue(32'h0000_3008, 3'd4, 4'b0101, 1'b0);
        wait_wb("t3", 100);
        check("t3_buffered", {31'd0, read_valid}, 32'd1);
        check("t3_head", read_data, 32'h1111_1111);
        drain_rd("t3", 20);
        tick();
        check("t3_empty_after", {31'd0, read_valid}, 32'd0);

        // Line write with spaced data, plus a request that arrives while busy.
        for (int i = 0; i < 4; i++) begin
            d = 32'hA000_0001 + i;
            exp_beat(32'h0000_4000 | ((32'h4 * (i + 1)) & 32'hC), 4'hF, 1'b1, d);
        end
        issue(32'h0000_4004, 3'd4, 4'b0010, 1'b1);
        issue(32'h0000_9000, 3'd1, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            repeat (2) tick();
            wr_beat(32'hA000_0001 + i);
        end
        wait_wb("t4", 100);
        check("t4_req_ready_idle", {31'd0, req_ready}, 32'd1);
        check("t4_overrun", overrun_cnt, 32'd1);

        // Error beat, then a silent slave that trips the timeout.
        slv_mode = 1;
        exp_beat(32'h0000_5000, 4'hF, 1'b0, 32'd0);
        exp_rd.push_back(ErrData);
        issue(32'h0000_5000, 3'd1, 4'hF, 1'b0);
        wait_wb("t5_err", 50);
        slv_mode = 2;
        exp_beat(32'h0000_5010, 4'b0011, 1'b0, 32'd0);
        exp_rd.push_back(ErrData);
        issue(32'h0000_5010, 3'd1, 4'b0011, 1'b0);
        wait_wb("t5_tmo", 400);
        check("t5_tmo_cyc_len", last_cyc_len, Timeout);
        check("t5_bus_err", bus_err_cnt, 32'd2);
        slv_mode = 0;
        drain_rd("t5", 20);

        // Reset during beat 2 of a line read; a later single read must still work.
        slv_delay = 3;
        slv_q.push_back(32'h0000_6000);
        slv_q.push_back(32'h0000_6004);
        exp_beat(32'h0000_6000, 4'hF, 1'b0, 32'd0);
        exp_beat(32'h0000_6004, 4'hF, 1'b0, 32'd0);
        exp_beat(32'h0000_6008, 4'hF, 1'b0, 32'd0);
        starts0 = wb_starts;
        issue(32'h0000_6000, 3'd4, 4'hF, 1'b0);
        n = 0;
        while (wb_starts < starts0 + 3 && n < 200) begin
            tick();
            n++;
        end
        check("t6_reached_beat2", wb_starts - starts0, 32'd3);
        check("t6_cyc_before_rst", {31'd0, wb_cyc_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        check("t6_cyc_after_rst", {31'd0, wb_cyc_o}, 32'd0);
        check("t6_read_valid", {31'd0, read_valid}, 32'd0);
        check("t6_req_ready", {31'd0, req_ready}, 32'd1);
        rst_i = 1'b0;
        exp_wb.delete();
        exp_rd.delete();
        slv_q.delete();
        slv_delay = 2;
        tick();
        slv_q.push_back(32'h1234_5678);
        exp_beat(32'h0000_7004, 4'hF, 1'b0, 32'd0);
        exp_rd.push_back(32'h1234_5678);
        issue(32'h0000_7004, 3'd1, 4'hF, 1'b0);
        wait_wb("t6_after", 50);
        drain_rd("t6_after", 20);

        repeat (3) tick();
        check("final_bus_err", bus_err_cnt, 32'd2);
        check("final_overrun", overrun_cnt, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
